div_rem_sequencer: RTL and testbench
====================================

// Module: div_rem_sequencer
// PURPOSE
//  Multi-cycle controller for the M-extension divide path. Replaces the combinational
//  div/rem ALU operation with a radix-2 restoring sequencer (one quotient bit per clock).
//  Sits beside the ALU. The control unit raises start for DIV/DIVU/REM/REMU.
//  The core freezes PC and register write on stall and writes back result when done pulses.
// PARAMETERS
//  WIDTH         32  operand/result width in bits; iteration count = WIDTH
//  FAST_SPECIAL  1   1: divide-by-zero and signed overflow finish in 1 cycle; 0: full WIDTH iterations
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request; sampled only in IDLE
//  op        in   2      funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend  in   WIDTH  rs1 value, captured on accepted start
//  divisor   in   WIDTH  rs2 value, captured on accepted start
//  busy      out  1      high in CALC and DONE
//  done      out  1      one-cycle pulse, result valid
//  stall     out  1      (start & IDLE) | CALC; combinational, holds PC/RegWrite
//  result    out  WIDTH  quotient (op[1]=0) or remainder (op[1]=1); registered
// BEHAVIOUR
//  Reset (async): state=IDLE; busy=0, done=0, result=0; counter, remainder, quotient regs cleared.
//  FSM:
//   IDLE->CALC on start. Capture op and |operands| (abs only when op[0]=0).
//     Record neg_q = sign(dividend)^sign(divisor) and neg_r = sign(dividend) (signed ops only).
//   IDLE->DONE directly on start when FAST_SPECIAL=1 and the operation is special.
//   CALC: each cycle shift {rem,quo} left 1; trial = rem - divisor.
//     If trial >= 0 (no borrow): rem = trial, quo[0] = 1.
//     Counter runs WIDTH-1 down to 0. At 0 go to DONE.
//   DONE: done=1 for exactly one cycle; result loaded on entry; unconditionally ->IDLE.
//  Latency: start accepted in cycle 0 -> done in cycle WIDTH+1 (33 for WIDTH=32).
//    Fast path -> done in cycle 1.
//  Sign fixup on CALC->DONE:
//    quotient = neg_q ? -quo : quo
//    remainder = neg_r ? -rem : rem
//    Both are two's complement, truncated to WIDTH.
//  Special cases (RISC-V defined, no trap):
//   divisor==0: quotient = all ones; remainder = dividend (unmodified, any op).
//   signed, dividend==100..0 and divisor==all ones: quotient = dividend; remainder = 0.
//   With FAST_SPECIAL=0 the same values are still produced, forced on the DONE entry.
//  Handshake:
//   start while busy is ignored: no recapture, no restart.
//   start held high through DONE re-triggers only in the following IDLE cycle.
//  result holds its last value through IDLE until the next DONE entry.
//  reset mid-CALC/DONE: immediate IDLE; busy, done and stall drop to 0.
//    No done pulse for the aborted op.
//  Operands that change after acceptance have no effect.
// TESTING
//  1 DIVU 100/7: start cycle 0 -> stall high in cycles 0..32; done=1 in cycle 33 only,
//    result=14. REMU same operands -> 2.
//  2 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
//  3 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5.
//    With FAST_SPECIAL=1, done in cycle 1 and stall only in cycle 0.
//  4 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  5 start pulse at cycle 5 with operands 9/3 while CALC (started cycle 0) runs:
//    the first op's result is unchanged, exactly one done pulse, state IDLE afterwards.
//  6 reset asserted asynchronously in cycle 10 of CALC: busy, done and stall go 0 immediately,
//    result=0, and no done pulse follows. A new start afterwards completes normally.

Source files
------------

// File: rtl/div_rem_if.sv
// Handshake and operand/result bundle between the control unit and the
// multi-cycle divide/remainder sequencer.
interface div_rem_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, dividend, divisor,
    input  busy, done, stall, result
  );

  modport slave (
    input  start, op, dividend, divisor,
    output busy, done, stall, result
  );
endinterface

// File: rtl/div_rem_sequencer.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per clock,
// RISC-V special cases (divide by zero, signed overflow) handled without trapping.
module div_rem_sequencer #(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input logic     clk,
  input logic     reset,
  div_rem_if.slave bus
);

  localparam int               CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    ZERO_C  = {CW{1'b0}};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic             want_rem;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic             ovf;
  logic [WIDTH-1:0] orig_a;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    count;

  logic             accept;
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic             in_div0;
  logic             in_ovf;
  logic             in_special;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] sp_result;

  // Decode the request: absolute operands, signs and special-case detection.
  always_comb begin
    accept     = (state == IDLE) && bus.start;
    signed_op  = ~bus.op[0];
    a_neg      = signed_op & bus.dividend[WIDTH-1];
    b_neg      = signed_op & bus.divisor[WIDTH-1];
    a_abs      = a_neg ? (ZERO - bus.dividend) : bus.dividend;
    b_abs      = b_neg ? (ZERO - bus.divisor) : bus.divisor;
    in_div0    = (bus.divisor == ZERO);
    in_ovf     = signed_op && (bus.dividend == MIN_NEG) && (bus.divisor == ONES);
    in_special = in_div0 | in_ovf;
    if (in_div0) begin
      sp_result = bus.op[1] ? bus.dividend : ONES;
    end else begin
      sp_result = bus.op[1] ? ZERO : bus.dividend;
    end
  end

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic [WIDTH-1:0] calc_result;

  // One restoring step plus the sign fixup / special override used on the last step.
  // The partial remainder never exceeds the divisor, so the trial's top bit is the borrow.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dsr};
    fits     = ~trial[WIDTH];
    rem_step = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], fits};
    if (div0) begin
      q_final = ONES;
      r_final = orig_a;
    end else if (ovf) begin
      q_final = orig_a;
      r_final = ZERO;
    end else begin
      q_final = neg_q ? (ZERO - quo_step) : quo_step;
      r_final = neg_r ? (ZERO - rem_step) : rem_step;
    end
    calc_result = want_rem ? r_final : q_final;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (FAST_SPECIAL && in_special) ? DONE : CALC;
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        if (count == ZERO_C) begin
          next_state = DONE;
        end else begin
          next_state = CALC;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      want_rem <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      orig_a   <= ZERO;
      dsr      <= ZERO;
      rem      <= ZERO;
      quo      <= ZERO;
      count    <= ZERO_C;
      result   <= ZERO;
    end else if (accept) begin
      want_rem <= bus.op[1];
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div0     <= in_div0;
      ovf      <= in_ovf;
      orig_a   <= bus.dividend;
      dsr      <= b_abs;
      rem      <= ZERO;
      quo      <= a_abs;
      count    <= LAST;
      if (FAST_SPECIAL && in_special) begin
        result <= sp_result;
      end
    end else if (state == CALC) begin
      rem   <= rem_step;
      quo   <= quo_step;
      count <= count - ONE_C;
      if (count == ZERO_C) begin
        result <= calc_result;
      end
    end
  end

  assign bus.busy   = (state == CALC) || (state == DONE);
  assign bus.done   = (state == DONE);
  assign bus.stall  = accept || (state == CALC);
  assign bus.result = result;

endmodule

// File: tb/tb_div_rem_sequencer.sv
// Scoreboard bench: a fast-special and a full-iteration sequencer share stimulus;
// expected results and done cycles are queued at start and popped on done.
module tb_div_rem_sequencer;

  localparam logic [31:0] ONES    = 32'hFFFF_FFFF;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   done_cnt_f;
  int   done_cnt_s;
  exp_t q_f[$];
  exp_t q_s[$];
  exp_t ef;
  exp_t es;

  div_rem_if #(.WIDTH(32)) bus_f ();
  div_rem_if #(.WIDTH(32)) bus_s ();

  assign bus_s.start    = bus_f.start;
  assign bus_s.op       = bus_f.op;
  assign bus_s.dividend = bus_f.dividend;
  assign bus_s.divisor  = bus_f.divisor;

  div_rem_sequencer #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  div_rem_sequencer #(.WIDTH(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : ONES;
    if (!o[0] && a == MIN_NEG && b == ONES) return o[1] ? 32'd0 : a;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Fast-path DUT scoreboard.
  always @(negedge clk) begin
    if (bus_f.done === 1'b1) begin
      done_cnt_f++;
      check("done_expected_f", 32'(q_f.size() != 0), 32'd1);
      if (q_f.size() != 0) begin
        ef = q_f.pop_front();
        check({ef.tag, "_res_f"}, bus_f.result, ef.res);
        check({ef.tag, "_lat_f"}, 32'(cyc), 32'(ef.cyc));
      end
    end
  end

  // Full-iteration DUT scoreboard.
  always @(negedge clk) begin
    if (bus_s.done === 1'b1) begin
      done_cnt_s++;
      check("done_expected_s", 32'(q_s.size() != 0), 32'd1);
      if (q_s.size() != 0) begin
        es = q_s.pop_front();
        check({es.tag, "_res_s"}, bus_s.result, es.res);
        check({es.tag, "_lat_s"}, 32'(cyc), 32'(es.cyc));
      end
    end
  end

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!o[0] && a == MIN_NEG && b == ONES);
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input string tag, output int st_n);
    int c0;
    @(negedge clk);
    bus_f.start    = 1'b1;
    bus_f.op       = o;
    bus_f.dividend = a;
    bus_f.divisor  = b;
    c0 = cyc;
    q_f.push_back('{exp_res, c0 + (is_special(o, a, b) ? 1 : 33), tag});
    q_s.push_back('{exp_res, c0 + 33, tag});
    #1 st_n = bus_f.stall ? 1 : 0;
    @(posedge clk);
    #1;
    bus_f.start    = 1'b0;
    bus_f.op       = 2'($urandom);
    bus_f.dividend = $urandom;
    bus_f.divisor  = $urandom;
  endtask

  task automatic wait_empty(input string tag, inout int st_n);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 60 && !fin; i++) begin
      @(negedge clk);
      #1;
      if (bus_f.stall) st_n++;
      if (q_f.size() == 0 && q_s.size() == 0) fin = 1'b1;
    end
    check({tag, "_finished"}, 32'(fin), 32'd1);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input string tag);
    int st_n;
    issue(o, a, b, exp_res, tag, st_n);
    wait_empty(tag, st_n);
    check({tag, "_stall_cycles"}, 32'(st_n), is_special(o, a, b) ? 32'd1 : 32'd33);
    @(negedge clk);
    check({tag, "_hold"}, bus_f.result, exp_res);
    check({tag, "_idle"}, {31'd0, bus_f.busy | bus_s.busy}, 32'd0);
  endtask

  initial begin
    int st_n;
    int base_f;
    int base_s;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    n_checks       = 0;
    n_pass         = 0;
    done_cnt_f     = 0;
    done_cnt_s     = 0;
    reset          = 1'b1;
    bus_f.start    = 1'b0;
    bus_f.op       = 2'b00;
    bus_f.dividend = 32'd0;
    bus_f.divisor  = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'd0, bus_f.busy},  32'd0);
    check("rst_done",   {31'd0, bus_f.done},  32'd0);
    check("rst_stall",  {31'd0, bus_f.stall}, 32'd0);
    check("rst_result", bus_f.result,          32'd0);
    reset = 1'b0;

    run_op(2'b01, 32'd100, 32'd7, 32'd14, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 32'd2,  "remu_100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2");
    run_op(2'b01, 32'd5, 32'd0, ONES, "divu_by0");
    run_op(2'b10, 32'd5, 32'd0, 32'd5, "rem_by0");
    run_op(2'b00, ONES, 32'd0, ONES, "div_m1_by0");
    run_op(2'b10, ONES, 32'd0, ONES, "rem_m1_by0");
    run_op(2'b00, MIN_NEG, ONES, MIN_NEG, "div_ovf");
    run_op(2'b10, MIN_NEG, ONES, 32'd0, "rem_ovf");
    run_op(2'b00, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, "div_20_m3");
    run_op(2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, "rem_m8_m3");
    run_op(2'b01, ONES, 32'd1, ONES, "divu_max_1");
    run_op(2'b11, ONES, 32'd16, 32'd15, "remu_max_16");

    for (int i = 0; i < 8; i++) begin
      o = 2'(i);
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 32'd0) b = 32'd3;
      run_op(o, a, b, model(o, a, b), $sformatf("rand%0d", i));
    end

    // A start pulse during CALC must be ignored.
    base_f = done_cnt_f;
    base_s = done_cnt_s;
    issue(2'b01, 32'd100, 32'd7, 32'd14, "busy_start", st_n);
    repeat (4) @(negedge clk);
    bus_f.start    = 1'b1;
    bus_f.op       = 2'b01;
    bus_f.dividend = 32'd9;
    bus_f.divisor  = 32'd3;
    @(posedge clk);
    #1 bus_f.start = 1'b0;
    wait_empty("busy_start", st_n);
    repeat (40) @(negedge clk);
    check("busy_start_dones_f", 32'(done_cnt_f - base_f), 32'd1);
    check("busy_start_dones_s", 32'(done_cnt_s - base_s), 32'd1);
    check("busy_start_idle", {31'd0, bus_f.busy}, 32'd0);
    check("busy_start_result", bus_f.result, 32'd14);

    // Asynchronous reset in the middle of CALC aborts with no done pulse.
    issue(2'b01, 32'd1000, 32'd3, 32'd333, "abort", st_n);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy",   {31'd0, bus_f.busy},  32'd0);
    check("abort_done",   {31'd0, bus_f.done},  32'd0);
    check("abort_stall",  {31'd0, bus_f.stall}, 32'd0);
    check("abort_result", bus_f.result,          32'd0);
    q_f.delete();
    q_s.delete();
    base_f = done_cnt_f;
    base_s = done_cnt_s;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done_f", 32'(done_cnt_f - base_f), 32'd0);
    check("abort_no_done_s", 32'(done_cnt_s - base_s), 32'd0);
    run_op(2'b00, 32'd1000, 32'd3, 32'd333, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
